// File: rtl/fir_resampler_pkg.sv
// Shared types, widths and parameter legality helpers for the FIR resampler feeder.
package fir_resampler_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int phase_width(input int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

  function automatic bit step_ok(input int step, input int l);
    return (step >= 1) && (step <= l);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fir_feed_fifo.sv
// Input sample buffer: registered pointers, head word readable combinationally.
module fir_feed_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             pop_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  // Blocked operations are dropped so the level never leaves 0..DEPTH.
  assign w_push     = push_i && !full_o;
  assign w_pop      = pop_i && !empty_o;
  assign empty_o    = (r_level == '0);
  assign full_o     = (r_level == (AW+1)'(DEPTH));
  assign level_o    = r_level;
  assign pop_data_o = r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fir_resampler_feeder.sv
// Drives the FIR resampler core: fixed request grid, phase accumulator decides sample pushes.
module fir_resampler_feeder
  import fir_resampler_pkg::*;
#(
  parameter int DATA_WIDTH    = SAMPLE_W,
  parameter int INTERPOLATION = 32,
  parameter int PHASE_STEP    = 1,
  parameter int TICK_PERIOD   = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int PHASE_W       = phase_width(INTERPOLATION)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [DATA_WIDTH-1:0]         s_data_i,
  input  logic                          s_val_i,
  output logic                          s_rdy_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          data_val_o,
  output logic                          data_req_o,
  output logic [PHASE_W-1:0]            phase_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underflow_o,
  input  logic                          clr_err_i
);
  localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD + 1) : 1;

  if (!step_ok(PHASE_STEP, INTERPOLATION)) begin : g_bad_step
    $error("PHASE_STEP must lie in 1..INTERPOLATION");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_fire;
  logic                  w_stall;
  logic                  w_pop;
  logic [PHASE_W:0]      w_sum;
  logic                  w_wrap;
  logic [PHASE_W-1:0]    w_acc_nxt;

  logic [PHASE_W-1:0]    r_acc;
  logic                  r_need;
  logic [TW-1:0]         r_tick;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dval;
  logic                  r_req;
  logic [PHASE_W-1:0]    r_phase;
  logic                  r_uflow;

  fir_feed_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_WIDTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (s_val_i),
    .push_data_i (s_data_i),
    .pop_i       (w_pop),
    .pop_data_o  (w_head),
    .empty_o     (w_empty),
    .full_o      (w_full),
    .level_o     (fifo_level_o)
  );

  // A request that needs a sample waits on the grid slot until the FIFO has one.
  assign w_fire  = enable_i && (r_tick == '0) && (!r_need || !w_empty);
  assign w_stall = enable_i && (r_tick == '0) && r_need && w_empty;
  assign w_pop   = w_fire && r_need;

  assign w_sum     = {1'b0, r_acc} + (PHASE_W+1)'(PHASE_STEP);
  assign w_wrap    = (w_sum >= (PHASE_W+1)'(INTERPOLATION));
  assign w_acc_nxt = w_wrap ? PHASE_W'(w_sum - (PHASE_W+1)'(INTERPOLATION))
                            : PHASE_W'(w_sum);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_need  <= 1'b1;
      r_tick  <= '0;
      r_data  <= '0;
      r_dval  <= 1'b0;
      r_req   <= 1'b0;
      r_phase <= '0;
      r_uflow <= 1'b0;
    end else begin
      r_req  <= w_fire;
      r_dval <= w_pop;
      r_data <= w_pop ? w_head : '0;
      if (w_fire) begin
        r_phase <= r_acc;
        r_acc   <= w_acc_nxt;
        r_need  <= w_wrap;
        r_tick  <= TW'(TICK_PERIOD - 1);
      end else if (enable_i && (r_tick != '0)) begin
        r_tick <= r_tick - 1'b1;
      end
      // Setting wins over a simultaneous clear.
      if (w_stall)        r_uflow <= 1'b1;
      else if (clr_err_i) r_uflow <= 1'b0;
    end
  end

  assign s_rdy_o     = !w_full && !rst_i;
  assign data_o      = r_data;
  assign data_val_o  = r_dval;
  assign data_req_o  = r_req;
  assign phase_o     = r_phase;
  assign underflow_o = r_uflow;

endmodule

// File: tb/tb_fir_resampler_feeder.sv
// Randomized bench: two feeders (1/32 step, 25/32 step) checked against a queue-based model.
module tb_fir_resampler_feeder;
  import fir_resampler_pkg::*;

  localparam int L     = 32;
  localparam int DEPTH = 16;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    en = 1'b0, sval = 1'b0, clr = 1'b0;
  sample_t sdata = '0;

  logic       rdy [2];
  sample_t    dout[2];
  logic       dval[2];
  logic       dreq[2];
  logic [4:0] ph  [2];
  logic [4:0] lvl [2];
  logic       uf  [2];

  always #5 clk = ~clk;

  fir_resampler_feeder u_dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .s_data_i(sdata), .s_val_i(sval),
    .s_rdy_o(rdy[0]), .data_o(dout[0]), .data_val_o(dval[0]), .data_req_o(dreq[0]),
    .phase_o(ph[0]), .fifo_level_o(lvl[0]), .underflow_o(uf[0]), .clr_err_i(clr)
  );

  fir_resampler_feeder #(.PHASE_STEP(25), .TICK_PERIOD(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .s_data_i(sdata), .s_val_i(sval),
    .s_rdy_o(rdy[1]), .data_o(dout[1]), .data_val_o(dval[1]), .data_req_o(dreq[1]),
    .phase_o(ph[1]), .fifo_level_o(lvl[1]), .underflow_o(uf[1]), .clr_err_i(clr)
  );

  // Reference model: sample queues plus phase/grid bookkeeping in plain integers.
  int      step[2] = '{1, 25};
  int      tper[2] = '{32, 4};
  int      m_acc[2], m_tc[2], m_ph[2];
  bit      m_need[2], m_uf[2];
  bit      e_req[2], e_val[2];
  sample_t e_data[2];
  sample_t q0[$];
  sample_t q1[$];

  int n_chk = 0, n_err = 0;
  int n_req0 = 0, n_val0 = 0, sum_val0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic sample_t qhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(input int k, input sample_t v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_tc[k] = 0; m_ph[k] = 0; m_need[k] = 1'b1; m_uf[k] = 1'b0;
      e_req[k] = 1'b0; e_val[k] = 1'b0; e_data[k] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit empty, full, fire, stall;
      int sum;
      empty = (qsize(k) == 0);
      full  = (qsize(k) == DEPTH);
      fire  = en && (m_tc[k] == 0) && (!m_need[k] || !empty);
      stall = en && (m_tc[k] == 0) && m_need[k] && empty;
      e_req[k]  = fire;
      e_val[k]  = fire && m_need[k];
      e_data[k] = e_val[k] ? qhead(k) : sample_t'(0);
      if (e_val[k]) qpop(k);
      if (sval && !full) qpush(k, sdata);
      if (stall)    m_uf[k] = 1'b1;
      else if (clr) m_uf[k] = 1'b0;
      if (fire) begin
        sum       = m_acc[k] + step[k];
        m_ph[k]   = m_acc[k];
        m_need[k] = (sum >= L);
        m_acc[k]  = m_need[k] ? sum - L : sum;
        m_tc[k]   = tper[k] - 1;
      end else if (en && m_tc[k] != 0) begin
        m_tc[k]--;
      end
    end
  endtask

  task automatic check_outs(input string ctx);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/u%0d req", ctx, k),   dreq[k], e_req[k]);
      chk($sformatf("%s/u%0d val", ctx, k),   dval[k], e_val[k]);
      chk($sformatf("%s/u%0d data", ctx, k),  dout[k], e_data[k]);
      chk($sformatf("%s/u%0d phase", ctx, k), ph[k],   m_ph[k]);
      chk($sformatf("%s/u%0d level", ctx, k), lvl[k],  qsize(k));
      chk($sformatf("%s/u%0d uflow", ctx, k), uf[k],   m_uf[k]);
      chk($sformatf("%s/u%0d rdy", ctx, k),   rdy[k],  !rst && (qsize(k) < DEPTH));
    end
  endtask

  task automatic tick(input string ctx = "run");
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
    check_outs(ctx);
    if (dreq[0]) n_req0++;
    if (dval[0]) begin
      n_val0++;
      sum_val0 += int'(dout[0]);
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs("async");
    repeat (2) tick("inrst");
    rst = 1'b0;
  endtask

  int vals[4] = '{100, 200, 300, 400};
  int dens;

  initial begin
    // Reset held with a valid input: nothing accepted, no strobes.
    sval = 1'b1; sdata = 16'h1234;
    repeat (10) tick("reset");
    rst = 1'b0; sval = 1'b0;
    tick("postrst");

    // Interpolation grid: preload four samples, then one sample per 32 requests.
    foreach (vals[i]) begin
      sval = 1'b1; sdata = sample_t'(vals[i]);
      tick("preload");
    end
    sval = 1'b0; en = 1'b1;
    n_req0 = 0; n_val0 = 0; sum_val0 = 0;
    repeat (97 * 32 + 8) tick("grid");
    chk("grid_req_count", n_req0, 98);
    chk("grid_val_count", n_val0, 4);
    chk("grid_val_sum", sum_val0, 1000);

    // Random traffic with varying input density.
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (15) begin
      dens = $urandom_range(0, 3);
      dens = (dens == 0) ? 5 : (dens == 1) ? 20 : (dens == 2) ? 40 : 95;
      repeat (200) begin
        sval  = ($urandom_range(0, 99) < dens);
        sdata = sample_t'($urandom);
        en    = ($urandom_range(0, 15) != 0);
        clr   = ($urandom_range(0, 31) == 0);
        tick();
      end
    end
    sval = 1'b0; clr = 1'b0;

    // Underflow: enabled with an empty FIFO, then a single sample arrives.
    async_reset();
    en = 1'b1;
    tick("uf_wait");
    chk("uf_set", uf[0], 1'b1);
    sval = 1'b1; sdata = 16'sd5;
    tick("uf_write");
    chk("uf_no_req_yet", dreq[0], 1'b0);
    sval = 1'b0;
    tick("uf_issue");
    chk("uf_req", dreq[0], 1'b1);
    chk("uf_data", dout[0], 16'd5);
    clr = 1'b1; tick("uf_clr"); clr = 1'b0;
    chk("uf_cleared", uf[0], 1'b0);

    // Reset in the middle of a phase-only stretch (acc = 17 on the slow feeder).
    async_reset();
    en = 1'b0; sval = 1'b1; sdata = 16'h0777;
    tick("acc_pre");
    sval = 1'b0; en = 1'b1;
    repeat (17 * 32) tick("acc_run");
    chk("acc17_last_phase", ph[0], 5'd16);
    async_reset();
    en = 1'b0; sval = 1'b1; sdata = 16'h0abc;
    tick("after_rst_write");
    sval = 1'b0; en = 1'b1;
    tick("after_rst_req");
    chk("after_rst_val", dval[0], 1'b1);
    chk("after_rst_phase", ph[0], 5'd0);

    // Full: 17 writes with requests disabled, then enable.
    async_reset();
    en = 1'b0;
    repeat (17) begin
      sval = 1'b1; sdata = sample_t'($urandom);
      tick("fill");
    end
    sval = 1'b0;
    chk("full_level", lvl[0], 5'd16);
    chk("full_rdy", rdy[0], 1'b0);
    en = 1'b1;
    tick("first_pop");
    chk("rdy_after_pop", rdy[0], 1'b1);

    repeat (400) begin
      sval  = ($urandom_range(0, 3) != 0);
      sdata = sample_t'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
